// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one byte per request from
// instruction memory, and presents the decoded fields to the decode/execute side.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int OP       = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic              instr_valid,
  output logic [OP-1:0]     op,
  output logic [1:0]        ra,
  output logic [1:0]        rb,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              ex_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  // state | meaning
  // IDLE  | not fetching; leaves once halt is low
  // FETCH | request outstanding at fetch_pc, waiting for imem_valid
  // ISSUE | instruction register valid, waiting for ex_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= ADDR_W'(RESET_PC);
      instr_pc <= '0;
      ir       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) state <= FETCH;
        end
        FETCH: begin
          if (imem_valid) begin
            ir       <= imem_rdata;
            instr_pc <= fetch_pc;
            fetch_pc <= fetch_pc + 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ex_ready) begin
            // A redirect still lands in fetch_pc when halting, so fetch resumes there.
            if (redirect) fetch_pc <= redirect_pc;
            state <= halt ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == ISSUE);
  assign imem_addr   = fetch_pc;
  assign op          = ir[INSTR_W-1 -: OP];
  assign ra          = ir[3:2];
  assign rb          = ir[1:0];

endmodule
